// File: rtl/show_sw_scan.sv
// Multi-channel switch viewer: per-channel synchronise + debounce of active-low
// switch nibbles, committed values on a scanned 7-seg display, history on LEDs.
module show_sw_scan #(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SCAN_CYCLES     = 1000
) (
  input  logic                  clock,
  input  logic                  reset_,
  input  logic [4*CHANNELS-1:0] switch_,
  output logic [CHANNELS-1:0]   num_selector_,
  output logic [6:0]            num_output,
  output logic [4*CHANNELS-1:0] led,
  output logic [CHANNELS-1:0]   changed
);

  localparam int CntW  = $clog2(DEBOUNCE_CYCLES);
  localparam int ScanW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int DigW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [CntW-1:0]  CntMax  = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [ScanW-1:0] ScanMax = ScanW'(SCAN_CYCLES - 1);
  localparam logic [DigW-1:0]  DigMax  = DigW'(CHANNELS - 1);

  logic [CHANNELS-1:0][3:0]      s1_q, s1_d, s2_q, s2_d;
  logic [CHANNELS-1:0][3:0]      cand_q, cand_d, cur_q, cur_d, prev_q, prev_d;
  logic [CHANNELS-1:0][CntW-1:0] cnt_q, cnt_d;
  logic [CHANNELS-1:0]           changed_q, changed_d;
  logic [ScanW-1:0]              scan_q, scan_d;
  logic [DigW-1:0]               digit_q, digit_d;
  logic [CHANNELS-1:0]           sel_q, sel_d;
  logic [6:0]                    seg_q, seg_d;

  function automatic logic [6:0] seg(input logic [3:0] v);
    case (v)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
  endfunction

  // A new candidate restarts the window; a full window commits only a real change.
  always_comb begin
    s1_d      = s1_q;
    s2_d      = s2_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    cur_d     = cur_q;
    prev_d    = prev_q;
    changed_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      s1_d[i] = ~switch_[4*i +: 4];
      s2_d[i] = s1_q[i];
      if (s2_q[i] != cand_q[i]) begin
        cand_d[i] = s2_q[i];
        cnt_d[i]  = '0;
      end else if (cnt_q[i] != CntMax) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (cand_q[i] != cur_q[i]) begin
        prev_d[i]    = cur_q[i];
        cur_d[i]     = cand_q[i];
        changed_d[i] = 1'b1;
      end
    end
  end

  // Display outputs are registered from the current digit so selector and segments move together.
  always_comb begin
    scan_d  = scan_q + 1'b1;
    digit_d = digit_q;
    if (scan_q == ScanMax) begin
      scan_d  = '0;
      digit_d = (digit_q == DigMax) ? '0 : digit_q + 1'b1;
    end
    sel_d = ~(CHANNELS'(1) << digit_q);
    seg_d = seg(cur_q[digit_q]);
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      s1_q      <= '0;
      s2_q      <= '0;
      cand_q    <= '0;
      cnt_q     <= '0;
      cur_q     <= '0;
      prev_q    <= '0;
      changed_q <= '0;
      scan_q    <= '0;
      digit_q   <= '0;
      sel_q     <= '1;
      seg_q     <= '0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      cur_q     <= cur_d;
      prev_q    <= prev_d;
      changed_q <= changed_d;
      scan_q    <= scan_d;
      digit_q   <= digit_d;
      sel_q     <= sel_d;
      seg_q     <= seg_d;
    end
  end

  assign led           = prev_q;
  assign changed       = changed_q;
  assign num_selector_ = sel_q;
  assign num_output    = seg_q;

endmodule

// File: tb/tb_show_sw_scan.sv
// Directed bench for show_sw_scan with CHANNELS=4, DEBOUNCE_CYCLES=4, SCAN_CYCLES=8.
module tb_show_sw_scan;

  localparam int CH = 4;
  localparam int DB = 4;
  localparam int SC = 8;
  // Input changed just after a falling edge is seen on the (DB+3)-th following falling edge.
  localparam int PulseAt = DB + 3;

  logic          clock = 1'b0;
  logic          reset_;
  logic [15:0]   switch_;
  logic [3:0]    num_selector_;
  logic [6:0]    num_output;
  logic [15:0]   led;
  logic [3:0]    changed;

  int checks = 0;
  int errors = 0;

  show_sw_scan #(.CHANNELS(CH), .DEBOUNCE_CYCLES(DB), .SCAN_CYCLES(SC)) dut (
    .clock(clock),
    .reset_(reset_),
    .switch_(switch_),
    .num_selector_(num_selector_),
    .num_output(num_output),
    .led(led),
    .changed(changed)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Waits for the selector to newly switch to sel; does no comparison itself.
  task automatic waitDigit(input logic [3:0] sel, output bit found);
    logic [3:0] lastSel;
    found = 1'b0;
    lastSel = num_selector_;
    for (int w = 0; w < 80 && !found; w++) begin
      @(negedge clock);
      if (num_selector_ == sel && lastSel != sel) found = 1'b1;
      lastSel = num_selector_;
    end
  endtask

  task automatic test_reset();
    int pulses;
    reset_ = 1'b0;
    switch_ = 16'hFFFF;
    repeat (3) @(negedge clock);
    checks++; if (num_selector_ !== 4'hF) begin errors++; $display("[TB] FAIL reset_sel: got %h expected %h", num_selector_, 4'hF); end
    checks++; if (num_output !== 7'h00) begin errors++; $display("[TB] FAIL reset_seg: got %h expected %h", num_output, 7'h00); end
    checks++; if (led !== 16'h0000) begin errors++; $display("[TB] FAIL reset_led: got %h expected %h", led, 16'h0000); end
    checks++; if (changed !== 4'h0) begin errors++; $display("[TB] FAIL reset_changed: got %h expected %h", changed, 4'h0); end
    reset_ = 1'b1;
    @(negedge clock);
    checks++; if (num_selector_ !== 4'b1110) begin errors++; $display("[TB] FAIL first_edge_sel: got %b expected %b", num_selector_, 4'b1110); end
    checks++; if (num_output !== 7'h3F) begin errors++; $display("[TB] FAIL first_edge_seg: got %h expected %h", num_output, 7'h3F); end
    pulses = 0;
    repeat (100) begin
      @(negedge clock);
      if (changed !== 4'h0) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("[TB] FAIL idle_pulses: got %0d expected 0", pulses); end
    checks++; if (led !== 16'h0000) begin errors++; $display("[TB] FAIL idle_led: got %h expected %h", led, 16'h0000); end
  endtask

  task automatic test_channel0_steps();
    logic [3:0] rawSeq [5];
    logic [6:0] expSeg [5];
    logic [3:0] expLed [5];
    int pulses, pulseAt, others, total;
    bit found;
    rawSeq = '{4'h8, 4'h9, 4'hE, 4'h2, 4'h0};
    expSeg = '{7'h07, 7'h7D, 7'h06, 7'h5E, 7'h71};
    expLed = '{4'h0, 4'h7, 4'h6, 4'h1, 4'hD};
    total = 0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clock);
      switch_[3:0] = rawSeq[s];
      pulses = 0; pulseAt = 0; others = 0;
      for (int k = 1; k <= 20; k++) begin
        @(negedge clock);
        if (changed[0] === 1'b1) begin pulses++; pulseAt = k; end
        if (changed[3:1] !== 3'b000) others++;
      end
      total += pulses;
      checks++; if (pulses != 1 || pulseAt != PulseAt) begin errors++; $display("[TB] FAIL ch0_pulse step %0d: got %0d pulses at %0d expected 1 at %0d", s, pulses, pulseAt, PulseAt); end
      checks++; if (others != 0) begin errors++; $display("[TB] FAIL ch0_other_pulses step %0d: got %0d expected 0", s, others); end
      checks++; if (led[3:0] !== expLed[s]) begin errors++; $display("[TB] FAIL ch0_led step %0d: got %h expected %h", s, led[3:0], expLed[s]); end
      waitDigit(4'b1110, found);
      checks++;
      if (!found) begin errors++; $display("[TB] FAIL ch0_digit_wait step %0d: got timeout expected digit 0", s); end
      else if (num_output !== expSeg[s]) begin errors++; $display("[TB] FAIL ch0_seg step %0d: got %h expected %h", s, num_output, expSeg[s]); end
    end
    checks++; if (total != 5) begin errors++; $display("[TB] FAIL ch0_total_pulses: got %0d expected 5", total); end
  endtask

  task automatic test_bounce();
    int pulses1, others;
    bit found;
    pulses1 = 0; others = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clock);
      switch_[7:4] = (t % 2 == 0) ? 4'hA : 4'h5;
      repeat (2) begin
        @(negedge clock);
        if (changed[1] === 1'b1) pulses1++;
        if ({changed[3:2], changed[0]} !== 3'b000) others++;
      end
    end
    repeat (20) begin
      @(negedge clock);
      if (changed[1] === 1'b1) pulses1++;
      if ({changed[3:2], changed[0]} !== 3'b000) others++;
    end
    checks++; if (pulses1 != 1) begin errors++; $display("[TB] FAIL bounce_pulses: got %0d expected 1", pulses1); end
    checks++; if (others != 0) begin errors++; $display("[TB] FAIL bounce_other_pulses: got %0d expected 0", others); end
    checks++; if (led !== 16'h000D) begin errors++; $display("[TB] FAIL bounce_led: got %h expected %h", led, 16'h000D); end
    waitDigit(4'b1101, found);
    checks++;
    if (!found) begin errors++; $display("[TB] FAIL bounce_digit_wait: got timeout expected digit 1"); end
    else if (num_output !== 7'h77) begin errors++; $display("[TB] FAIL bounce_seg: got %h expected %h", num_output, 7'h77); end
  endtask

  task automatic test_simultaneous();
    logic [6:0] scanSeg [4];
    logic [3:0] expSel, atPulse;
    int pulses0, others, d;
    bit found;
    scanSeg = '{7'h71, 7'h79, 7'h5E, 7'h39};
    @(negedge clock);
    switch_ = 16'hFF5F;
    pulses0 = 0;
    repeat (20) begin
      @(negedge clock);
      if (changed[0] === 1'b1) pulses0++;
    end
    checks++; if (pulses0 != 1) begin errors++; $display("[TB] FAIL prep_ch0_pulses: got %0d expected 1", pulses0); end
    checks++; if (led !== 16'h000F) begin errors++; $display("[TB] FAIL prep_led: got %h expected %h", led, 16'h000F); end
    @(negedge clock);
    switch_ = 16'h3210;
    atPulse = 4'h0; others = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (k == PulseAt) atPulse = changed;
      else if (changed !== 4'h0) others++;
    end
    checks++; if (atPulse !== 4'hF) begin errors++; $display("[TB] FAIL simul_changed: got %h expected %h", atPulse, 4'hF); end
    checks++; if (others != 0) begin errors++; $display("[TB] FAIL simul_stray_pulses: got %0d expected 0", others); end
    checks++; if (led !== 16'h00A0) begin errors++; $display("[TB] FAIL simul_led: got %h expected %h", led, 16'h00A0); end
    waitDigit(4'b1110, found);
    checks++;
    if (!found) begin
      errors++; $display("[TB] FAIL scan_wait: got timeout expected digit 0 entry");
    end else begin
      for (int i = 0; i <= 4 * SC; i++) begin
        if (i > 0) @(negedge clock);
        d = (i / SC) % 4;
        expSel = ~(4'b0001 << d);
        checks++;
        if (num_selector_ !== expSel || num_output !== scanSeg[d]) begin
          errors++;
          $display("[TB] FAIL scan cycle %0d: got %b/%h expected %b/%h", i, num_selector_, num_output, expSel, scanSeg[d]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_debounce();
    logic [3:0] atPulse;
    int pulses, others;
    bit found;
    @(negedge clock);
    switch_[11:8] = 4'h7;
    pulses = 0;
    repeat (4) begin
      @(negedge clock);
      if (changed !== 4'h0) pulses++;
    end
    @(negedge clock);
    reset_ = 1'b0;
    #1;
    checks++; if (num_selector_ !== 4'hF) begin errors++; $display("[TB] FAIL midreset_sel: got %h expected %h", num_selector_, 4'hF); end
    checks++; if (num_output !== 7'h00) begin errors++; $display("[TB] FAIL midreset_seg: got %h expected %h", num_output, 7'h00); end
    checks++; if (led !== 16'h0000) begin errors++; $display("[TB] FAIL midreset_led: got %h expected %h", led, 16'h0000); end
    repeat (3) begin
      @(negedge clock);
      if (changed !== 4'h0) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("[TB] FAIL midreset_pulses: got %0d expected 0", pulses); end
    reset_ = 1'b1;
    atPulse = 4'h0; others = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (k == 1) begin
        checks++;
        if (num_selector_ !== 4'b1110 || num_output !== 7'h3F) begin
          errors++; $display("[TB] FAIL rerelease_display: got %b/%h expected %b/%h", num_selector_, num_output, 4'b1110, 7'h3F);
        end
      end
      if (k == PulseAt) atPulse = changed;
      else if (changed !== 4'h0) others++;
    end
    checks++; if (atPulse !== 4'hF) begin errors++; $display("[TB] FAIL fresh_commit: got %h expected %h", atPulse, 4'hF); end
    checks++; if (others != 0) begin errors++; $display("[TB] FAIL fresh_stray_pulses: got %0d expected 0", others); end
    checks++; if (led !== 16'h0000) begin errors++; $display("[TB] FAIL fresh_led: got %h expected %h", led, 16'h0000); end
    waitDigit(4'b1011, found);
    checks++;
    if (!found) begin errors++; $display("[TB] FAIL fresh_digit_wait: got timeout expected digit 2"); end
    else if (num_output !== 7'h7F) begin errors++; $display("[TB] FAIL fresh_seg: got %h expected %h", num_output, 7'h7F); end
  endtask

  task automatic test_glitch_same_value();
    int pulses;
    bit found;
    pulses = 0;
    @(negedge clock);
    switch_[15:12] = 4'h0;
    repeat (3) begin
      @(negedge clock);
      if (changed !== 4'h0) pulses++;
    end
    switch_[15:12] = 4'h3;
    repeat (20) begin
      @(negedge clock);
      if (changed !== 4'h0) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("[TB] FAIL glitch_pulses: got %0d expected 0", pulses); end
    checks++; if (led !== 16'h0000) begin errors++; $display("[TB] FAIL glitch_led: got %h expected %h", led, 16'h0000); end
    waitDigit(4'b0111, found);
    checks++;
    if (!found) begin errors++; $display("[TB] FAIL glitch_digit_wait: got timeout expected digit 3"); end
    else if (num_output !== 7'h39) begin errors++; $display("[TB] FAIL glitch_seg: got %h expected %h", num_output, 7'h39); end
  endtask

  initial begin
    test_reset();
    test_channel0_steps();
    test_bounce();
    test_simultaneous();
    test_reset_mid_debounce();
    test_glitch_same_value();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
